multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/legv8_pkg.sv | 75 +++++++
 rtl/multicycle_ctrl_if.sv | 37 +++
 rtl/legv8_decode.sv | 78 +++++++
 rtl/multicycle_ctrl.sv | 157 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/legv8_pkg.sv
// LEGv8 multicycle control: shared encodings, opcode patterns and the control bundle.
package legv8_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_TRAP   = 3'b101
  } state_t;

  typedef enum logic [3:0] {
    C_ILL, C_R, C_I, C_SH, C_LD,
    C_ST, C_CBZ, C_CBNZ, C_B
  } cls_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_PSB = 3'b100;
  localparam logic [2:0] ALU_LSL = 3'b101;
  localparam logic [2:0] ALU_LSR = 3'b110;

  localparam logic [1:0] SEU_I  = 2'b00;
  localparam logic [1:0] SEU_D  = 2'b01;
  localparam logic [1:0] SEU_B  = 2'b10;
  localparam logic [1:0] SEU_CB = 2'b11;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ADDI = 11'b10010001000;
  localparam logic [10:0] OP_SUBI = 11'b11010001000;
  localparam logic [10:0] OP_ANDI = 11'b10010010000;
  localparam logic [10:0] OP_ORRI = 11'b10110010000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_CBNZ = 11'b10110101000;
  localparam logic [10:0] OP_B    = 11'b00010100000;

  localparam logic [10:0] M_R  = 11'b11111111111;
  localparam logic [10:0] M_I  = 11'b11111111110;
  localparam logic [10:0] M_CB = 11'b11111111000;
  localparam logic [10:0] M_B  = 11'b11111100000;

  typedef struct packed {
    logic       pc_wr;
    logic       ir_wr;
    logic       pc_src;
    logic       reg2loc;
    logic       alu_src;
    logic       mem_to_reg;
    logic [1:0] seu;
    logic [2:0] alu_op;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic       mem_err;
  } ctl_t;

  function automatic logic op_match(
    input logic [10:0] op,
    input logic [10:0] pat,
    input logic [10:0] msk
  );
    return ((op ^ pat) & msk) == 11'd0;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control-unit bus: instruction/flag/memory inputs and datapath control outputs.
interface multicycle_ctrl_if;
  logic [10:0] opcode;
  logic        zero;
  logic        mem_ready;
  logic        bus_pcWr;
  logic        bus_irWr;
  logic        bus_pcSrc;
  logic        bus_reg2loc;
  logic        bus_aluSrc;
  logic        bus_memToReg;
  logic [1:0]  bus_seu;
  logic [2:0]  bus_aluOp;
  logic        bus_memRd;
  logic        bus_memWr;
  logic        bus_regWr;
  logic        bus_memErr;
  logic [2:0]  state;

  modport master (
    input  opcode, zero, mem_ready,
    output bus_pcWr, bus_irWr, bus_pcSrc,
    output bus_reg2loc, bus_aluSrc, bus_memToReg,
    output bus_seu, bus_aluOp,
    output bus_memRd, bus_memWr, bus_regWr,
    output bus_memErr, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  bus_pcWr, bus_irWr, bus_pcSrc,
    input  bus_reg2loc, bus_aluSrc, bus_memToReg,
    input  bus_seu, bus_aluOp,
    input  bus_memRd, bus_memWr, bus_regWr,
    input  bus_memErr, state
  );
endinterface

// File: rtl/legv8_decode.sv
// Combinational opcode classifier: instruction class, ALU op and immediate format.
module legv8_decode
  import legv8_pkg::*;
(
  input  logic [10:0] i_opcode,
  output cls_t        o_cls,
  output logic [2:0]  o_alu_op,
  output logic [1:0]  o_seu
);

  always_comb begin
    o_cls    = C_ILL;
    o_alu_op = ALU_ADD;
    o_seu    = SEU_I;
    unique case (1'b1)
      op_match(i_opcode, OP_ADD, M_R):
        o_cls = C_R;
      op_match(i_opcode, OP_SUB, M_R): begin
        o_cls    = C_R;
        o_alu_op = ALU_SUB;
      end
      op_match(i_opcode, OP_AND, M_R): begin
        o_cls    = C_R;
        o_alu_op = ALU_AND;
      end
      op_match(i_opcode, OP_ORR, M_R): begin
        o_cls    = C_R;
        o_alu_op = ALU_ORR;
      end
      op_match(i_opcode, OP_ADDI, M_I):
        o_cls = C_I;
      op_match(i_opcode, OP_SUBI, M_I): begin
        o_cls    = C_I;
        o_alu_op = ALU_SUB;
      end
      op_match(i_opcode, OP_ANDI, M_I): begin
        o_cls    = C_I;
        o_alu_op = ALU_AND;
      end
      op_match(i_opcode, OP_ORRI, M_I): begin
        o_cls    = C_I;
        o_alu_op = ALU_ORR;
      end
      op_match(i_opcode, OP_LSL, M_R): begin
        o_cls    = C_SH;
        o_alu_op = ALU_LSL;
      end
      op_match(i_opcode, OP_LSR, M_R): begin
        o_cls    = C_SH;
        o_alu_op = ALU_LSR;
      end
      op_match(i_opcode, OP_LDUR, M_R): begin
        o_cls = C_LD;
        o_seu = SEU_D;
      end
      op_match(i_opcode, OP_STUR, M_R): begin
        o_cls = C_ST;
        o_seu = SEU_D;
      end
      op_match(i_opcode, OP_CBZ, M_CB): begin
        o_cls    = C_CBZ;
        o_alu_op = ALU_PSB;
        o_seu    = SEU_CB;
      end
      op_match(i_opcode, OP_CBNZ, M_CB): begin
        o_cls    = C_CBNZ;
        o_alu_op = ALU_PSB;
        o_seu    = SEU_CB;
      end
      op_match(i_opcode, OP_B, M_B): begin
        o_cls = C_B;
        o_seu = SEU_B;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// LEGv8 multicycle control FSM with memory wait timeout.
// Define CU_ILLEGAL_TRAP_EN to trap on unknown opcodes instead of treating them as NOP.
module multicycle_ctrl
  import legv8_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master cu
);

  localparam int WW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  state_t        r_state;
  state_t        w_next;
  cls_t          r_cls;
  cls_t          w_cls;
  logic [2:0]    w_alu_op;
  logic [1:0]    w_seu;
  logic [WW-1:0] r_wait;
  logic          w_mem_st;
  logic          w_tmo;
  ctl_t          w_ctl;

  legv8_decode u_dec (
    .i_opcode (cu.opcode),
    .o_cls    (w_cls),
    .o_alu_op (w_alu_op),
    .o_seu    (w_seu)
  );

  assign w_mem_st = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_tmo    = w_mem_st && (r_wait == WW'(WAIT_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Class is latched in EXEC so MEM/WB ignore later opcode changes
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_cls <= C_ILL;
    else if (r_state == S_EXEC) r_cls <= w_cls;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_wait <= '0;
    else if (!w_mem_st || cu.mem_ready || w_tmo || (w_next != r_state))
      r_wait <= '0;
    else
      r_wait <= r_wait + 1'b1;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH:
        if (!w_tmo && cu.mem_ready) w_next = S_DECODE;
      S_DECODE:
        case (w_cls)
          C_B: w_next = S_FETCH;
          C_ILL: begin
`ifdef CU_ILLEGAL_TRAP_EN
            w_next = S_TRAP;
`else
            w_next = S_FETCH;
`endif
          end
          default: w_next = S_EXEC;
        endcase
      S_EXEC:
        case (w_cls)
          C_LD, C_ST:      w_next = S_MEM;
          C_R, C_I, C_SH:  w_next = S_WB;
          default:         w_next = S_FETCH;
        endcase
      S_MEM:
        if (w_tmo)
          w_next = S_FETCH;
        else if (cu.mem_ready)
          w_next = (r_cls == C_LD) ? S_WB : S_FETCH;
      S_WB:    w_next = S_FETCH;
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_ctl = '0;
    if (!rst) begin
      unique case (r_state)
        S_FETCH:
          if (w_tmo) begin
            w_ctl.mem_err = 1'b1;
          end else begin
            w_ctl.mem_rd = 1'b1;
            w_ctl.ir_wr  = cu.mem_ready;
            w_ctl.pc_wr  = cu.mem_ready;
          end
        S_DECODE:
          if (w_cls == C_B) begin
            w_ctl.pc_wr  = 1'b1;
            w_ctl.pc_src = 1'b1;
            w_ctl.seu    = SEU_B;
          end
        S_EXEC: begin
          w_ctl.alu_op = w_alu_op;
          w_ctl.seu    = w_seu;
          case (w_cls)
            C_R: ;
            C_I, C_SH, C_LD:
              w_ctl.alu_src = 1'b1;
            C_ST: begin
              w_ctl.alu_src = 1'b1;
              w_ctl.reg2loc = 1'b1;
            end
            C_CBZ, C_CBNZ: begin
              w_ctl.reg2loc = 1'b1;
              w_ctl.pc_src  = 1'b1;
              w_ctl.pc_wr   = (w_cls == C_CBZ) ? cu.zero : !cu.zero;
            end
            default: begin
              w_ctl.alu_op = '0;
              w_ctl.seu    = '0;
            end
          endcase
        end
        S_MEM:
          if (w_tmo)                w_ctl.mem_err = 1'b1;
          else if (r_cls == C_LD)   w_ctl.mem_rd  = 1'b1;
          else                      w_ctl.mem_wr  = 1'b1;
        S_WB: begin
          w_ctl.reg_wr     = 1'b1;
          w_ctl.mem_to_reg = (r_cls == C_LD);
        end
        default: ;
      endcase
    end
  end

  assign cu.bus_pcWr     = w_ctl.pc_wr;
  assign cu.bus_irWr     = w_ctl.ir_wr;
  assign cu.bus_pcSrc    = w_ctl.pc_src;
  assign cu.bus_reg2loc  = w_ctl.reg2loc;
  assign cu.bus_aluSrc   = w_ctl.alu_src;
  assign cu.bus_memToReg = w_ctl.mem_to_reg;
  assign cu.bus_seu      = w_ctl.seu;
  assign cu.bus_aluOp    = w_ctl.alu_op;
  assign cu.bus_memRd    = w_ctl.mem_rd;
  assign cu.bus_memWr    = w_ctl.mem_wr;
  assign cu.bus_regWr    = w_ctl.reg_wr;
  assign cu.bus_memErr   = w_ctl.mem_err;
  assign cu.state        = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with a per-cycle expected-output scoreboard.
// Honours CU_ILLEGAL_TRAP_EN for the unknown-opcode check.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  logic [17:0] sb[$];

  localparam logic [2:0] F = 3'b000;
  localparam logic [2:0] D = 3'b001;
  localparam logic [2:0] E = 3'b010;
  localparam logic [2:0] M = 3'b011;
  localparam logic [2:0] W = 3'b100;
  localparam logic [2:0] T = 3'b101;

  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] ORR  = 11'b10101010000;
  localparam logic [10:0] SUBI = 11'b11010001001;
  localparam logic [10:0] LSR  = 11'b11010011010;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [10:0] CBZ  = 11'b10110100101;
  localparam logic [10:0] CBNZ = 11'b10110101011;
  localparam logic [10:0] BR   = 11'b00010100000;
  localparam logic [10:0] ILL  = 11'b00000000000;

  multicycle_ctrl_if cu();

  multicycle_ctrl #(.WAIT_MAX(15)) dut (
    .clk (clk),
    .rst (rst),
    .cu  (cu)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] ctl(
    input logic pw, iw, ps, r2, as, m2r,
    input logic [1:0] seu,
    input logic [2:0] alu,
    input logic mr, mw, rw, me
  );
    return {pw, iw, ps, r2, as, m2r, seu, alu, mr, mw, rw, me};
  endfunction

  function automatic logic [17:0] observe();
    return {cu.state, cu.bus_pcWr, cu.bus_irWr, cu.bus_pcSrc,
            cu.bus_reg2loc, cu.bus_aluSrc, cu.bus_memToReg,
            cu.bus_seu, cu.bus_aluOp, cu.bus_memRd,
            cu.bus_memWr, cu.bus_regWr, cu.bus_memErr};
  endfunction

  task automatic compare(input string tag);
    logic [17:0] e;
    logic [17:0] o;
    e = sb.pop_front();
    o = observe();
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Called at posedge+1: drive, check mid-cycle, advance to next posedge+1
  task automatic step(
    input string tag, input logic [10:0] op,
    input logic z, input logic rdy,
    input logic [2:0] st, input logic [14:0] c
  );
    cu.opcode    = op;
    cu.zero      = z;
    cu.mem_ready = rdy;
    sb.push_back({st, c});
    @(negedge clk);
    compare(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [14:0] c0, cf, cfr, cwb;
    c0  = '0;
    cf  = ctl(0,0,0,0,0,0,2'b00,3'b000,1,0,0,0);
    cfr = ctl(1,1,0,0,0,0,2'b00,3'b000,1,0,0,0);
    cwb = ctl(0,0,0,0,0,0,2'b00,3'b000,0,0,1,0);

    rst          = 1'b1;
    cu.opcode    = ADD;
    cu.zero      = 1'b0;
    cu.mem_ready = 1'b1;
    #2;
    sb.push_back({F, c0});
    compare("reset_hold");
    @(posedge clk);
    #1;
    rst = 1'b0;

    step("add_fetch", ADD, 0, 1, F, cfr);
    step("add_dec",   ADD, 0, 1, D, c0);
    step("add_exec",  ADD, 0, 1, E, c0);
    step("add_wb",    ADD, 0, 1, W, cwb);

    step("ld_fetch", LDUR, 0, 1, F, cfr);
    step("ld_dec",   LDUR, 0, 1, D, c0);
    step("ld_exec",  LDUR, 0, 1, E,
         ctl(0,0,0,0,1,0,2'b01,3'b000,0,0,0,0));
    step("ld_mem0",  LDUR, 0, 0, M, ctl(0,0,0,0,0,0,2'b00,3'b000,1,0,0,0));
    step("ld_mem1",  STUR, 0, 0, M, ctl(0,0,0,0,0,0,2'b00,3'b000,1,0,0,0));
    step("ld_mem2",  ILL,  0, 0, M, ctl(0,0,0,0,0,0,2'b00,3'b000,1,0,0,0));
    step("ld_mem3",  ADD,  0, 1, M, ctl(0,0,0,0,0,0,2'b00,3'b000,1,0,0,0));
    step("ld_wb",    ADD,  0, 1, W, ctl(0,0,0,0,0,1,2'b00,3'b000,0,0,1,0));

    step("cbz0_fetch", CBZ, 0, 1, F, cfr);
    step("cbz0_dec",   CBZ, 0, 1, D, c0);
    step("cbz0_exec",  CBZ, 0, 1, E,
         ctl(0,0,1,1,0,0,2'b11,3'b100,0,0,0,0));
    step("cbz1_fetch", CBZ, 1, 1, F, cfr);
    step("cbz1_dec",   CBZ, 1, 1, D, c0);
    step("cbz1_exec",  CBZ, 1, 1, E,
         ctl(1,0,1,1,0,0,2'b11,3'b100,0,0,0,0));
    step("cbnz_fetch", CBNZ, 0, 1, F, cfr);
    step("cbnz_dec",   CBNZ, 0, 1, D, c0);
    step("cbnz_exec",  CBNZ, 0, 1, E,
         ctl(1,0,1,1,0,0,2'b11,3'b100,0,0,0,0));

    step("b_fetch", BR, 0, 1, F, cfr);
    step("b_dec",   BR, 0, 1, D,
         ctl(1,0,1,0,0,0,2'b10,3'b000,0,0,0,0));
    step("b_next",  SUBI, 0, 1, F, cfr);

    step("subi_dec",  SUBI, 0, 1, D, c0);
    step("subi_exec", SUBI, 0, 1, E,
         ctl(0,0,0,0,1,0,2'b00,3'b001,0,0,0,0));
    step("subi_wb",   SUBI, 0, 1, W, cwb);

    step("orr_fetch", ORR, 0, 1, F, cfr);
    step("orr_dec",   ORR, 0, 1, D, c0);
    step("orr_exec",  ORR, 0, 1, E,
         ctl(0,0,0,0,0,0,2'b00,3'b011,0,0,0,0));
    step("orr_wb",    ORR, 0, 1, W, cwb);

    step("lsr_fetch", LSR, 0, 1, F, cfr);
    step("lsr_dec",   LSR, 0, 1, D, c0);
    step("lsr_exec",  LSR, 0, 1, E,
         ctl(0,0,0,0,1,0,2'b00,3'b110,0,0,0,0));
    step("lsr_wb",    LSR, 0, 1, W, cwb);

    for (int i = 0; i < 15; i++)
      step("tmo_wait", STUR, 0, 0, F, cf);
    step("tmo_err",   STUR, 0, 0, F,
         ctl(0,0,0,0,0,0,2'b00,3'b000,0,0,0,1));
    step("tmo_retry", STUR, 0, 0, F, cf);
    step("st_fetch",  STUR, 0, 1, F, cfr);
    step("st_dec",    STUR, 0, 1, D, c0);
    step("st_exec",   STUR, 0, 1, E,
         ctl(0,0,0,1,1,0,2'b01,3'b000,0,0,0,0));

    cu.mem_ready = 1'b0;
    sb.push_back({M, ctl(0,0,0,0,0,0,2'b00,3'b000,0,1,0,0)});
    @(negedge clk);
    compare("st_mem");
    #2;
    rst = 1'b1;
    sb.push_back({F, c0});
    #1;
    compare("st_async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    step("ill_fetch", ILL, 0, 1, F, cfr);
    step("ill_dec",   ILL, 0, 1, D, c0);
`ifdef CU_ILLEGAL_TRAP_EN
    step("ill_trap0", ILL, 0, 1, T, c0);
    step("ill_trap1", ADD, 0, 1, T, c0);
`else
    step("ill_nop",   ILL, 0, 0, F, cf);
    step("ill_next",  ADD, 0, 1, F, cfr);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
